// File: rtl/tvip_axi_types_pkg.sv
// Shared AXI write-channel field bundles and the state type for the two-way write arbiter.
// The _ext variants carry one extra id bit that records which requester owns a burst.
package tvip_axi_types_pkg;

  localparam int TVIP_AXI_ID_WIDTH   = 4;
  localparam int TVIP_AXI_ADDR_WIDTH = 32;
  localparam int TVIP_AXI_DATA_WIDTH = 32;
  localparam int TVIP_AXI_STRB_WIDTH = TVIP_AXI_DATA_WIDTH / 8;

  typedef logic [TVIP_AXI_ID_WIDTH-1:0] tvip_axi_id;
  typedef logic [TVIP_AXI_ID_WIDTH:0]   tvip_axi_id_ext;

  typedef struct packed {
    tvip_axi_id                     id;
    logic [TVIP_AXI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                     len;
    logic [2:0]                     size;
    logic [1:0]                     burst;
    logic [3:0]                     cache;
    logic [2:0]                     prot;
    logic [3:0]                     qos;
  } tvip_axi_write_address;

  typedef struct packed {
    tvip_axi_id_ext                 id;
    logic [TVIP_AXI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                     len;
    logic [2:0]                     size;
    logic [1:0]                     burst;
    logic [3:0]                     cache;
    logic [2:0]                     prot;
    logic [3:0]                     qos;
  } tvip_axi_write_address_ext;

  typedef struct packed {
    logic [TVIP_AXI_DATA_WIDTH-1:0] data;
    logic [TVIP_AXI_STRB_WIDTH-1:0] strb;
    logic                           last;
  } tvip_axi_write_data;

  // W beats carry no id, so the widened variant is the same bundle.
  typedef tvip_axi_write_data tvip_axi_write_data_ext;

  typedef struct packed {
    tvip_axi_id id;
    logic [1:0] resp;
  } tvip_axi_write_response;

  typedef struct packed {
    tvip_axi_id_ext id;
    logic [1:0]     resp;
  } tvip_axi_write_response_ext;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } tvip_axi_write_arbiter_state;

endpackage

// File: rtl/tvip_axi_rr_arbiter.sv
// Combinational two-requester grant selection: round-robin against the previous winner,
// or fixed priority with requester 0 on top.
module tvip_axi_rr_arbiter #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    case (req)
      2'b10:   grant = 1'b1;
      2'b11:   grant = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/tvip_axi_write_arbiter.sv
// Two-to-one AXI write arbiter: one burst at a time owns AW then W; the B channel is routed
// back by the extra id MSB and never waits on the arbitration state.
module tvip_axi_write_arbiter
  import tvip_axi_types_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [1:0]                      s_awvalid,
  output logic [1:0]                      s_awready,
  input  tvip_axi_write_address [1:0]     s_aw,
  input  logic [1:0]                      s_wvalid,
  output logic [1:0]                      s_wready,
  input  tvip_axi_write_data [1:0]        s_w,
  output logic [1:0]                      s_bvalid,
  input  logic [1:0]                      s_bready,
  output tvip_axi_write_response          s_b,
  output logic                            m_awvalid,
  input  logic                            m_awready,
  output tvip_axi_write_address_ext       m_aw,
  output logic                            m_wvalid,
  input  logic                            m_wready,
  output tvip_axi_write_data              m_w,
  input  logic                            m_bvalid,
  output logic                            m_bready,
  input  tvip_axi_write_response_ext      m_b,
  output logic                            err_wlast
);

  tvip_axi_write_arbiter_state state_reg, state_next;
  logic                        grant_reg, grant_next;
  logic                        last_grant_reg, last_grant_next;
  logic [7:0]                  beat_cnt_reg, beat_cnt_next;
  logic                        err_wlast_reg, err_wlast_next;
  logic                        arb_grant;
  logic                        b_route;
  tvip_axi_write_address       sel_aw;
  tvip_axi_write_data          sel_w;

  tvip_axi_rr_arbiter #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arbiter (
    .req        (s_awvalid),
    .last_grant (last_grant_reg),
    .grant      (arb_grant)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      beat_cnt_reg   <= '0;
      err_wlast_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      beat_cnt_reg   <= beat_cnt_next;
      err_wlast_reg  <= err_wlast_next;
    end
  end

  always_comb begin
    sel_aw          = s_aw[grant_reg];
    sel_w           = s_w[grant_reg];
    m_awvalid       = 1'b0;
    m_wvalid        = 1'b0;
    m_aw.id         = {grant_reg, sel_aw.id};
    m_aw.addr       = sel_aw.addr;
    m_aw.len        = sel_aw.len;
    m_aw.size       = sel_aw.size;
    m_aw.burst      = sel_aw.burst;
    m_aw.cache      = sel_aw.cache;
    m_aw.prot       = sel_aw.prot;
    m_aw.qos        = sel_aw.qos;
    m_w.data        = sel_w.data;
    m_w.strb        = sel_w.strb;
    // The burst length fixed at AW time is authoritative; the requester's own last is only audited.
    m_w.last        = (beat_cnt_reg == '0);
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    beat_cnt_next   = beat_cnt_reg;
    err_wlast_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|s_awvalid) begin
          grant_next = arb_grant;
          state_next = ADDR;
        end
      end
      ADDR: begin
        m_awvalid = s_awvalid[grant_reg];
        if (m_awvalid && m_awready) begin
          beat_cnt_next   = sel_aw.len;
          last_grant_next = grant_reg;
          state_next      = DATA;
        end
      end
      DATA: begin
        m_wvalid = s_wvalid[grant_reg];
        if (m_wvalid && m_wready) begin
          err_wlast_next = (sel_w.last != m_w.last);
          if (m_w.last) begin
            state_next = IDLE;
          end else begin
            beat_cnt_next = beat_cnt_reg - 8'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign b_route   = m_b.id[TVIP_AXI_ID_WIDTH];
  assign m_bready  = s_bready[b_route];
  assign s_b.id    = m_b.id[TVIP_AXI_ID_WIDTH-1:0];
  assign s_b.resp  = m_b.resp;
  assign err_wlast = err_wlast_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign s_awready[gi] = (state_reg == ADDR) && (grant_reg == 1'(gi)) && m_awready;
    assign s_wready[gi]  = (state_reg == DATA) && (grant_reg == 1'(gi)) && m_wready;
    assign s_bvalid[gi]  = m_bvalid && (b_route == 1'(gi));
  end

endmodule

// File: tb/tb_tvip_axi_write_arbiter.sv
// Directed bench for the two-way AXI write arbiter: a burst-level reference model checked
// every cycle, plus literal expectations for latency, grant order, B routing, wlast and reset.
module tb_tvip_axi_write_arbiter;
  import tvip_axi_types_pkg::*;

  logic                        aclk = 1'b0;
  logic                        areset = 1'b1;
  logic [1:0]                  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  tvip_axi_write_address [1:0] s_aw;
  tvip_axi_write_data [1:0]    s_w;
  tvip_axi_write_response      s_b;
  logic                        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  tvip_axi_write_address_ext   m_aw;
  tvip_axi_write_data          m_w;
  tvip_axi_write_response_ext  m_b;
  logic                        err_wlast;

  // Fixed-priority instance shares every input; only its grant order is examined.
  logic [1:0]                  fp_s_awready, fp_s_wready, fp_s_bvalid;
  tvip_axi_write_response      fp_s_b;
  logic                        fp_m_awvalid, fp_m_wvalid, fp_m_bready, fp_err_wlast;
  tvip_axi_write_address_ext   fp_m_aw;
  tvip_axi_write_data          fp_m_w;

  int vectors = 0;
  int miscompares = 0;

  always #5 aclk = ~aclk;

  tvip_axi_write_arbiter #(.ROUND_ROBIN(1)) dut (
    .aclk(aclk), .areset(areset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w(s_w),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_b(s_b),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw(m_aw),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_w(m_w),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_b(m_b),
    .err_wlast(err_wlast)
  );

  tvip_axi_write_arbiter #(.ROUND_ROBIN(0)) dut_fp (
    .aclk(aclk), .areset(areset),
    .s_awvalid(s_awvalid), .s_awready(fp_s_awready), .s_aw(s_aw),
    .s_wvalid(s_wvalid), .s_wready(fp_s_wready), .s_w(s_w),
    .s_bvalid(fp_s_bvalid), .s_bready(s_bready), .s_b(fp_s_b),
    .m_awvalid(fp_m_awvalid), .m_awready(m_awready), .m_aw(fp_m_aw),
    .m_wvalid(fp_m_wvalid), .m_wready(m_wready), .m_w(fp_m_w),
    .m_bvalid(m_bvalid), .m_bready(fp_m_bready), .m_b(m_b),
    .err_wlast(fp_err_wlast)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic set_aw(input int r, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    s_aw[r]       = '0;
    s_aw[r].id    = id;
    s_aw[r].addr  = addr;
    s_aw[r].len   = len;
    s_aw[r].size  = 3'd2;
    s_aw[r].burst = 2'd1;
    s_aw[r].qos   = 4'(r + 1);
  endtask

  // Burst-level reference: who owns the channel, whether its address went out, beats sent so far.
  bit md_act, md_awd, md_err;
  int md_who, md_len, md_beats;
  int md_prev = 1;

  function automatic int pick_winner(input logic [1:0] req, input int prev);
    if (req == 2'b11) return 1 - prev;
    if (req[1]) return 1;
    return 0;
  endfunction

  always @(negedge aclk) begin
    logic       e_awv, e_wv;
    logic [1:0] e_awr, e_wr, e_bv;
    int         k;
    bit         nerr;
    if (areset) begin
      md_act  = 1'b0;
      md_awd  = 1'b0;
      md_err  = 1'b0;
      md_prev = 1;
    end
    e_awv = md_act && !md_awd && s_awvalid[md_who];
    e_awr = (md_act && !md_awd && m_awready) ? 2'(1 << md_who) : 2'b00;
    e_wv  = md_act && md_awd && s_wvalid[md_who];
    e_wr  = (md_act && md_awd && m_wready) ? 2'(1 << md_who) : 2'b00;
    chk("m_awvalid", 64'(m_awvalid), 64'(e_awv));
    chk("s_awready", 64'(s_awready), 64'(e_awr));
    if (e_awv) begin
      chk("m_aw.id", 64'(m_aw.id), 64'({md_who[0], s_aw[md_who].id}));
      chk("m_aw.addr", 64'(m_aw.addr), 64'(s_aw[md_who].addr));
      chk("m_aw.len", 64'(m_aw.len), 64'(s_aw[md_who].len));
      chk("m_aw.qos", 64'(m_aw.qos), 64'(s_aw[md_who].qos));
    end
    chk("m_wvalid", 64'(m_wvalid), 64'(e_wv));
    chk("s_wready", 64'(s_wready), 64'(e_wr));
    if (e_wv) begin
      chk("m_w.data", 64'(m_w.data), 64'(s_w[md_who].data));
      chk("m_w.strb", 64'(m_w.strb), 64'(s_w[md_who].strb));
      chk("m_w.last", 64'(m_w.last), 64'(md_beats == md_len));
    end
    chk("err_wlast", 64'(err_wlast), 64'(md_err));
    k    = int'(m_b.id[4]);
    e_bv = m_bvalid ? 2'(1 << k) : 2'b00;
    chk("s_bvalid", 64'(s_bvalid), 64'(e_bv));
    chk("m_bready", 64'(m_bready), 64'(s_bready[k]));
    chk("s_b.id", 64'(s_b.id), 64'(m_b.id[3:0]));
    chk("s_b.resp", 64'(s_b.resp), 64'(m_b.resp));

    if (!areset) begin
      nerr = 1'b0;
      if (!md_act) begin
        if (s_awvalid != 2'b00) begin
          md_who   = pick_winner(s_awvalid, md_prev);
          md_act   = 1'b1;
          md_awd   = 1'b0;
          md_beats = 0;
        end
      end else if (!md_awd) begin
        if (e_awv && m_awready) begin
          md_awd  = 1'b1;
          md_len  = int'(s_aw[md_who].len);
          md_prev = md_who;
        end
      end else if (e_wv && m_wready) begin
        nerr = (s_w[md_who].last != (md_beats == md_len));
        md_beats++;
        if (md_beats > md_len) md_act = 1'b0;
      end
      md_err = nerr;
    end
  end

  initial begin
    int   nb, nl, lastat, nerr, err_at, n;
    logic awhs;
    logic rr_g [3];
    logic fp_g [3];
    s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_aw = '0; s_w = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_b = '0;

    // Reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst m_awvalid", 64'(m_awvalid), 64'd0);
    chk("rst m_wvalid", 64'(m_wvalid), 64'd0);
    chk("rst s_awready", 64'(s_awready), 64'd0);
    chk("rst s_wready", 64'(s_wready), 64'd0);
    chk("rst err_wlast", 64'(err_wlast), 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;

    // Requester 0 alone, awlen 3
    set_aw(0, 4'h3, 32'h0000_1000, 8'd3);
    s_w[0].data = 32'hA000_0000; s_w[0].strb = 4'hF; s_w[0].last = 1'b0;
    s_wvalid[0] = 1'b1; m_awready = 1'b1; m_wready = 1'b1; s_awvalid[0] = 1'b1;
    @(negedge aclk);
    chk("t1 idle cycle m_awvalid", 64'(m_awvalid), 64'd0);
    @(negedge aclk);
    chk("t1 m_awvalid at +1", 64'(m_awvalid), 64'd1);
    chk("t1 m_aw.id msb", 64'(m_aw.id[4]), 64'd0);
    @(posedge aclk); #1;
    s_awvalid[0] = 1'b0;
    nb = 0; nl = 0; lastat = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk);
      if (m_wvalid && m_wready) begin
        nb++;
        if (m_w.last) begin nl++; lastat = nb; end
      end
      @(posedge aclk); #1;
      s_w[0].data = 32'hA000_0000 + 32'(nb);
      s_w[0].last = (nb == 3);
      if (nb == 4) s_wvalid[0] = 1'b0;
    end
    chk("t1 beat count", 64'(nb), 64'd4);
    chk("t1 last count", 64'(nl), 64'd1);
    chk("t1 last beat", 64'(lastat), 64'd4);

    // Three simultaneous requests from a fresh reset; B traffic runs alongside
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    m_bvalid = 1'b1; m_b.id = 5'h07; m_b.resp = 2'b01; s_bready = 2'b01;
    set_aw(0, 4'h1, 32'h0000_2000, 8'd0);
    set_aw(1, 4'h2, 32'h0000_3000, 8'd0);
    s_w[0].data = 32'h1111_0000; s_w[0].strb = 4'h1; s_w[0].last = 1'b1;
    s_w[1].data = 32'h2222_0000; s_w[1].strb = 4'h2; s_w[1].last = 1'b1;
    s_wvalid = 2'b11; s_awvalid = 2'b11;
    n = 0;
    for (int c = 0; c < 30 && n < 3; c++) begin
      @(negedge aclk);
      if (m_awvalid && m_awready) begin
        chk("t2 fp m_awvalid", 64'(fp_m_awvalid), 64'd1);
        rr_g[n] = m_aw.id[4];
        fp_g[n] = fp_m_aw.id[4];
        n++;
      end
    end
    chk("t2 grants seen", 64'(n), 64'd3);
    @(posedge aclk); #1;
    s_awvalid = 2'b00;
    @(posedge aclk); #1;
    s_wvalid = 2'b00; m_bvalid = 1'b0; s_bready = 2'b00;
    if (n == 3) begin
      chk("t2 rr grant 1", 64'(rr_g[0]), 64'd0);
      chk("t2 rr grant 2", 64'(rr_g[1]), 64'd1);
      chk("t2 rr grant 3", 64'(rr_g[2]), 64'd0);
      chk("t2 fp grant 1", 64'(fp_g[0]), 64'd0);
      chk("t2 fp grant 2", 64'(fp_g[1]), 64'd0);
      chk("t2 fp grant 3", 64'(fp_g[2]), 64'd0);
    end

    // B response for requester 1 held while its bready is low
    m_bvalid = 1'b1; m_b.id = 5'h15; m_b.resp = 2'b10; s_bready = 2'b01;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      chk("t3 s_bvalid held", 64'(s_bvalid), 64'h2);
      chk("t3 s_b.id", 64'(s_b.id), 64'h5);
      chk("t3 m_bready low", 64'(m_bready), 64'd0);
    end
    @(posedge aclk); #1;
    s_bready = 2'b10;
    @(negedge aclk);
    chk("t3 m_bready high", 64'(m_bready), 64'd1);
    chk("t3 s_bvalid", 64'(s_bvalid), 64'h2);
    @(posedge aclk); #1;
    m_bvalid = 1'b0; s_bready = 2'b00;

    // awlen 1, requester 1 asserts last on its first beat
    set_aw(1, 4'h9, 32'h0000_4000, 8'd1);
    s_w[1].data = 32'h0000_00B0; s_w[1].strb = 4'h3; s_w[1].last = 1'b1;
    s_wvalid[1] = 1'b1; s_awvalid[1] = 1'b1;
    nb = 0; nl = 0; lastat = 0; nerr = 0; err_at = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      if (err_wlast) begin nerr++; err_at = nb; end
      if (m_wvalid && m_wready) begin
        nb++;
        if (m_w.last) begin nl++; lastat = nb; end
      end
      awhs = m_awvalid && m_awready;
      @(posedge aclk); #1;
      if (awhs) s_awvalid[1] = 1'b0;
      if (nb == 2) s_wvalid[1] = 1'b0;
      s_w[1].data = s_w[1].data + 32'd1;
    end
    chk("t4 err pulses", 64'(nerr), 64'd1);
    chk("t4 err after beat", 64'(err_at), 64'd1);
    chk("t4 last count", 64'(nl), 64'd1);
    chk("t4 last beat", 64'(lastat), 64'd2);

    // Reset in the middle of a 4-beat burst
    set_aw(1, 4'hC, 32'h0000_5000, 8'd3);
    s_w[1].last = 1'b0; s_wvalid[1] = 1'b1; s_awvalid[1] = 1'b1;
    nb = 0;
    for (int c = 0; c < 12 && nb < 2; c++) begin
      @(negedge aclk);
      if (m_wvalid && m_wready) nb++;
      awhs = m_awvalid && m_awready;
      @(posedge aclk); #1;
      if (awhs) s_awvalid[1] = 1'b0;
      s_w[1].data = s_w[1].data + 32'd1;
    end
    chk("t5 two beats before reset", 64'(nb), 64'd2);
    areset = 1'b1;
    @(negedge aclk);
    chk("t5 m_wvalid in reset", 64'(m_wvalid), 64'd0);
    chk("t5 s_wready in reset", 64'(s_wready), 64'd0);
    chk("t5 m_awvalid in reset", 64'(m_awvalid), 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    set_aw(0, 4'h4, 32'h0000_6000, 8'd0);
    s_w[0].last = 1'b1;
    s_awvalid = 2'b11; s_wvalid = 2'b11;
    @(negedge aclk);
    chk("t5 idle after reset", 64'(m_awvalid), 64'd0);
    @(negedge aclk);
    chk("t5 m_awvalid", 64'(m_awvalid), 64'd1);
    chk("t5 grant after reset", 64'(m_aw.id[4]), 64'd0);
    @(posedge aclk); #1;
    s_awvalid = 2'b00;
    @(posedge aclk); #1;
    s_wvalid = 2'b00;
    repeat (3) @(negedge aclk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tvip_axi_write_arbiter.md
TVIP_AXI_WRITE_ARBITER -- requirements
Module: tvip_axi_write_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as below.
REQ-002 Parameter ROUND_ROBIN, default 1: 1 = round-robin between requesters; 0 = fixed priority, requester 0 wins.
REQ-003 aclk  in  1  block clock; all state changes on the rising edge.
REQ-004 areset  in  1  asynchronous, active-high reset.
REQ-005 s_awvalid  in  2  per-requester write-address valid; bit i is requester i.
REQ-006 s_awready  out  2  per-requester write-address ready.
REQ-007 s_aw  in  2 x tvip_axi_write_address  per-requester fields: id, addr, len, size, burst, cache, prot, qos.
REQ-008 s_wvalid / s_wready  in / out  2 / 2  per-requester write-data handshake.
REQ-009 s_w  in  2 x tvip_axi_write_data  per-requester fields: data, strb, last.
REQ-010 s_bvalid / s_bready  out / in  2 / 2  per-requester write-response handshake.
REQ-011 s_b  out  tvip_axi_write_response  response fields (id, resp) broadcast to both requesters.
REQ-012 m_awvalid / m_awready  out / in  1 / 1  downstream write-address handshake.
REQ-013 m_aw  out  tvip_axi_write_address_ext  downstream address fields; id is tvip_axi_id width + 1.
REQ-014 m_wvalid / m_wready / m_w  out / in / out  1 / 1 / tvip_axi_write_data  downstream write-data channel.
REQ-015 m_bvalid / m_bready / m_b  in / out / in  1 / 1 / tvip_axi_write_response_ext  downstream write-response channel.
REQ-016 err_wlast  out  1  one-cycle pulse on a requester wlast mismatch.

Function
REQ-017 FSM states: IDLE, ADDR, DATA.
REQ-018 IDLE: if any s_awvalid is set, latch grant and next state ADDR; otherwise stay IDLE.
REQ-019 Grant, ROUND_ROBIN=1: single requester wins; if both request, the one not equal to last_grant wins.
REQ-020 Grant, ROUND_ROBIN=0: requester 0 wins whenever s_awvalid[0] is set.
REQ-021 ADDR: m_awvalid = s_awvalid[grant]; s_awready[grant] = m_awready; other fields pass from the granted requester.
REQ-022 ADDR: m_aw.id = {grant, s_aw[grant].id}.
REQ-023 ADDR: on m_awvalid && m_awready, load beat_cnt = awlen, set last_grant = grant, go DATA.
REQ-024 Latency: m_awvalid rises exactly 1 cycle after the first IDLE cycle with s_awvalid set.
REQ-025 DATA: m_wvalid = s_wvalid[grant]; s_wready[grant] = m_wready; data and strb pass through.
REQ-026 DATA: m_w.last = (beat_cnt == 0), regardless of s_w.last.
REQ-027 DATA: each W handshake decrements beat_cnt; a handshake with beat_cnt == 0 returns to IDLE.
REQ-028 DATA: a handshake where s_w.last differs from (beat_cnt == 0) pulses err_wlast for 1 cycle; the beat is still forwarded.
REQ-029 Non-granted requester: s_awready = 0 and s_wready = 0; in IDLE both are 0.
REQ-030 m_awvalid = 0 outside ADDR; m_wvalid = 0 outside DATA; W arriving before AW is held off.
REQ-031 B path is combinational and state-independent; k = m_b.id MSB.
REQ-032 B routing: s_bvalid[k] = m_bvalid; m_bready = s_bready[k]; s_b.id = m_b.id without MSB; resp passes through.
REQ-033 A new arbitration (IDLE with requests) SHALL not stall the B path; B responses from earlier bursts continue.
REQ-034 Burst of len 0: DATA lasts for exactly one handshake.

Reset
REQ-035 Asserting areset at any time forces state IDLE, grant 0, last_grant 1, beat_cnt 0, err_wlast 0.
REQ-036 During and after reset, all valid/ready outputs are 0 except combinational B routing; a reset mid-burst abandons the burst.

Structure
REQ-037 tvip_axi_types_pkg gains struct typedefs tvip_axi_write_address, tvip_axi_write_data and tvip_axi_write_response, plus their _ext variants with id widened by 1.
REQ-038 Grant logic lives in sub-module tvip_axi_rr_arbiter (2 requests, last_grant in, grant out; combinational).

Verification
REQ-039 Requester 0 alone, awlen=3, m_awready=m_wready=1 -> m_awvalid at cycle+1, 4 W beats, m_w.last on beat 4 only, m_aw.id MSB=0.
REQ-040 Both requesters assert AW together, three times -> grants 0,1,0 (ROUND_ROBIN=1); grants 0,0,0 (ROUND_ROBIN=0).
REQ-041 m_b.id = {1,4'h5}, s_bready[1]=0 for 3 cycles -> s_bvalid[1] held with s_b.id=5, s_bvalid[0]=0, m_bready=0 until s_bready[1] is set.
REQ-042 awlen=1, requester drives s_w.last on beat 1 -> err_wlast pulses at beat 1; m_w.last asserts on beat 2 only.
REQ-043 areset pulsed in DATA after 2 of 4 beats -> IDLE next cycle, m_wvalid=0, next arbitration grants requester 0.
